gelato_split_table: RTL and testbench

//  Per-warp SIMT divergence stack; consumer side of the I-Decode -> Split Table link.
//  I-Decode reads a warp's active thread mask combinationally.
//  On a branch it issues a diverge (activate=1) or a join (activate=0).
//  The table updates the warp's mask stack and, one cycle later, reports the resume mask/PC to the warp scheduler.

---
 rtl/gelato_split_table.sv | 147 ++++++++++++++
 tb/tb_gelato_split_table.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/gelato_split_table.sv
// Per-warp SIMT divergence stack: diverge pushes the taken mask, join merges the top into the entry below.
// Latency: thread_mask/depth are combinational; resume_* is registered, one cycle after the op. No backpressure: stall holds off the op.
module gelato_split_table #(
    parameter int WARP_NUM    = 4,
    parameter int SPLIT_DEPTH = 8,
    parameter int THREAD_NUM  = 32,
    parameter int ADDR_WIDTH  = 32,
    localparam int WW = $clog2(WARP_NUM),
    localparam int DW = $clog2(SPLIT_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WW-1:0]         warp_num,
    input  logic [DW-1:0]         split_table_num,
    output logic [THREAD_NUM-1:0] thread_mask,
    input  logic                  valid,
    input  logic                  stall,
    input  logic                  activate,
    input  logic [ADDR_WIDTH-1:0] updated_pc,
    input  logic [THREAD_NUM-1:0] cond_mask,
    output logic                  resume_valid,
    output logic [WW-1:0]         resume_warp,
    output logic [THREAD_NUM-1:0] resume_mask,
    output logic [ADDR_WIDTH-1:0] resume_pc,
    output logic                  overflow_err,
    output logic                  underflow_err,
    output logic [DW:0]           depth
);

    logic [THREAD_NUM-1:0] mask_q [WARP_NUM][SPLIT_DEPTH];
    logic [THREAD_NUM-1:0] mask_d [WARP_NUM][SPLIT_DEPTH];
    logic [ADDR_WIDTH-1:0] pc_q   [WARP_NUM][SPLIT_DEPTH];
    logic [ADDR_WIDTH-1:0] pc_d   [WARP_NUM][SPLIT_DEPTH];
    logic [DW-1:0]         sp_q   [WARP_NUM];
    logic [DW-1:0]         sp_d   [WARP_NUM];

    logic                  resume_valid_q, resume_valid_d;
    logic [WW-1:0]         resume_warp_q, resume_warp_d;
    logic [THREAD_NUM-1:0] resume_mask_q, resume_mask_d;
    logic [ADDR_WIDTH-1:0] resume_pc_q, resume_pc_d;
    logic                  overflow_err_q, overflow_err_d;
    logic                  underflow_err_q, underflow_err_d;

    logic                  fire;
    logic [DW-1:0]         sp_cur;
    logic [DW-1:0]         sp_below;
    logic [THREAD_NUM-1:0] top_mask;
    logic [THREAD_NUM-1:0] taken_mask;
    logic [THREAD_NUM-1:0] not_taken_mask;
    logic [THREAD_NUM-1:0] merged_mask;

    assign fire           = valid && !stall;
    assign sp_cur         = sp_q[warp_num];
    assign sp_below       = sp_cur - DW'(1);
    assign top_mask       = mask_q[warp_num][sp_cur];
    assign taken_mask     = top_mask & cond_mask;
    assign not_taken_mask = top_mask & ~cond_mask;
    assign merged_mask    = mask_q[warp_num][sp_below] | top_mask;

    // Entries above sp are always zero, but the read still masks them for robustness.
    assign thread_mask = (split_table_num <= sp_cur) ? mask_q[warp_num][split_table_num] : '0;
    assign depth       = {1'b0, sp_cur} + (DW+1)'(1);

    always_comb begin
        mask_d          = mask_q;
        pc_d            = pc_q;
        sp_d            = sp_q;
        overflow_err_d  = overflow_err_q;
        underflow_err_d = underflow_err_q;
        resume_valid_d  = 1'b0;
        resume_warp_d   = resume_warp_q;
        resume_mask_d   = resume_mask_q;
        resume_pc_d     = resume_pc_q;
        if (fire) begin
            if (activate) begin
                if (taken_mask == '0) begin
                    // Nobody takes the branch: warp falls through silently.
                end else if (not_taken_mask == '0) begin
                    resume_valid_d = 1'b1;
                    resume_warp_d  = warp_num;
                    resume_mask_d  = top_mask;
                    resume_pc_d    = updated_pc;
                end else if (sp_cur != DW'(SPLIT_DEPTH - 1)) begin
                    mask_d[warp_num][sp_cur]          = not_taken_mask;
                    mask_d[warp_num][sp_cur + DW'(1)] = taken_mask;
                    pc_d[warp_num][sp_cur + DW'(1)]   = updated_pc;
                    sp_d[warp_num]                    = sp_cur + DW'(1);
                    resume_valid_d = 1'b1;
                    resume_warp_d  = warp_num;
                    resume_mask_d  = taken_mask;
                    resume_pc_d    = updated_pc;
                end else begin
                    overflow_err_d = 1'b1;
                end
            end else begin
                if (sp_cur != '0) begin
                    mask_d[warp_num][sp_below] = merged_mask;
                    mask_d[warp_num][sp_cur]   = '0;
                    pc_d[warp_num][sp_cur]     = '0;
                    sp_d[warp_num]             = sp_below;
                    resume_valid_d = 1'b1;
                    resume_warp_d  = warp_num;
                    resume_mask_d  = merged_mask;
                    resume_pc_d    = updated_pc;
                end else begin
                    underflow_err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int w = 0; w < WARP_NUM; w++) begin
                sp_q[w] <= '0;
                for (int e = 0; e < SPLIT_DEPTH; e++) begin
                    mask_q[w][e] <= (e == 0) ? '1 : '0;
                    pc_q[w][e]   <= '0;
                end
            end
            resume_valid_q  <= 1'b0;
            resume_warp_q   <= '0;
            resume_mask_q   <= '0;
            resume_pc_q     <= '0;
            overflow_err_q  <= 1'b0;
            underflow_err_q <= 1'b0;
        end else begin
            mask_q          <= mask_d;
            pc_q            <= pc_d;
            sp_q            <= sp_d;
            resume_valid_q  <= resume_valid_d;
            resume_warp_q   <= resume_warp_d;
            resume_mask_q   <= resume_mask_d;
            resume_pc_q     <= resume_pc_d;
            overflow_err_q  <= overflow_err_d;
            underflow_err_q <= underflow_err_d;
        end
    end

    assign resume_valid  = resume_valid_q;
    assign resume_warp   = resume_warp_q;
    assign resume_mask   = resume_mask_q;
    assign resume_pc     = resume_pc_q;
    assign overflow_err  = overflow_err_q;
    assign underflow_err = underflow_err_q;

endmodule

// File: tb/tb_gelato_split_table.sv
// Directed bench for gelato_split_table: diverge/join, fall-through, overflow, underflow, stall and reset.
module tb_gelato_split_table;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  warp_num;
    logic [2:0]  split_table_num;
    logic [31:0] thread_mask;
    logic        valid;
    logic        stall;
    logic        activate;
    logic [31:0] updated_pc;
    logic [31:0] cond_mask;
    logic        resume_valid;
    logic [1:0]  resume_warp;
    logic [31:0] resume_mask;
    logic [31:0] resume_pc;
    logic        overflow_err;
    logic        underflow_err;
    logic [3:0]  depth;

    int checks   = 0;
    int failures = 0;

    gelato_split_table dut (
        .clk(clk), .rst(rst), .warp_num(warp_num), .split_table_num(split_table_num),
        .thread_mask(thread_mask), .valid(valid), .stall(stall), .activate(activate),
        .updated_pc(updated_pc), .cond_mask(cond_mask), .resume_valid(resume_valid),
        .resume_warp(resume_warp), .resume_mask(resume_mask), .resume_pc(resume_pc),
        .overflow_err(overflow_err), .underflow_err(underflow_err), .depth(depth)
    );

    always #5 clk = ~clk;

    // Present an op, clock it in, and land 1ns after the edge with valid still driven.
    task automatic op(input logic [1:0] w, input logic act, input logic [31:0] pc, input logic [31:0] cm);
        warp_num   = w;
        activate   = act;
        updated_pc = pc;
        cond_mask  = cm;
        valid      = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        valid = 1'b0;
        stall = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        valid = 1'b0; stall = 1'b0; activate = 1'b0;
        warp_num = '0; split_table_num = '0; updated_pc = '0; cond_mask = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (thread_mask !== 32'hFFFF_FFFF) begin failures++; $display("FAIL reset_mask got=%h exp=%h", thread_mask, 32'hFFFF_FFFF); end
        checks++; if (depth !== 4'd1) begin failures++; $display("FAIL reset_depth got=%0d exp=1", depth); end
        checks++; if ({resume_valid, resume_warp, resume_mask, resume_pc, overflow_err, underflow_err} !== '0)
            begin failures++; $display("FAIL reset_outputs rv=%b rw=%0d rm=%h rpc=%h ovf=%b unf=%b exp all 0",
                resume_valid, resume_warp, resume_mask, resume_pc, overflow_err, underflow_err); end
    endtask

    task automatic test_diverge_join();
        op(2'd1, 1'b1, 32'h100, 32'h0000_FFFF);
        checks++; if ({resume_valid, resume_warp} !== {1'b1, 2'd1}) begin failures++; $display("FAIL div_pulse rv=%b rw=%0d exp 1/1", resume_valid, resume_warp); end
        checks++; if (resume_mask !== 32'h0000_FFFF || resume_pc !== 32'h100) begin failures++; $display("FAIL div_resume mask=%h pc=%h exp 0000ffff/100", resume_mask, resume_pc); end
        idle();
        checks++; if (resume_valid !== 1'b0) begin failures++; $display("FAIL div_pulse_width rv=%b exp 0", resume_valid); end
        warp_num = 2'd1; split_table_num = 3'd0; #1;
        checks++; if (thread_mask !== 32'hFFFF_0000 || depth !== 4'd2) begin failures++; $display("FAIL div_state idx0=%h depth=%0d exp ffff0000/2", thread_mask, depth); end
        op(2'd1, 1'b0, 32'h180, 32'h0);
        checks++; if (resume_valid !== 1'b1 || resume_mask !== 32'hFFFF_FFFF || resume_pc !== 32'h180)
            begin failures++; $display("FAIL join_resume rv=%b mask=%h pc=%h exp 1/ffffffff/180", resume_valid, resume_mask, resume_pc); end
        idle();
        split_table_num = 3'd1; #1;
        checks++; if (thread_mask !== 32'h0 || depth !== 4'd1) begin failures++; $display("FAIL join_state idx1=%h depth=%0d exp 0/1", thread_mask, depth); end
    endtask

    task automatic test_fallthrough();
        split_table_num = 3'd0;
        op(2'd0, 1'b1, 32'h200, 32'h0);
        checks++; if (resume_valid !== 1'b0 || depth !== 4'd1) begin failures++; $display("FAIL cond_zero rv=%b depth=%0d exp 0/1", resume_valid, depth); end
        op(2'd0, 1'b1, 32'h240, 32'hFFFF_FFFF);
        checks++; if (resume_valid !== 1'b1 || resume_mask !== 32'hFFFF_FFFF || resume_pc !== 32'h240 || depth !== 4'd1)
            begin failures++; $display("FAIL cond_all rv=%b mask=%h pc=%h depth=%0d exp 1/ffffffff/240/1", resume_valid, resume_mask, resume_pc, depth); end
        idle();
    endtask

    task automatic test_overflow();
        logic [31:0] exp_top;
        exp_top = 32'hFFFF_FFFF;
        // Each split peels one thread off into the not-taken side, so both halves stay non-empty.
        for (int k = 0; k < 7; k++) begin
            exp_top = exp_top & ~(32'h1 << k);
            op(2'd2, 1'b1, 32'h1000 + 32'(k * 4), ~(32'h1 << k));
            checks++; if (resume_valid !== 1'b1 || resume_mask !== exp_top || depth !== 4'(k + 2))
                begin failures++; $display("FAIL nest%0d rv=%b mask=%h depth=%0d exp 1/%h/%0d", k, resume_valid, resume_mask, depth, exp_top, k + 2); end
        end
        op(2'd2, 1'b1, 32'h2000, ~(32'h1 << 7));
        checks++; if (resume_valid !== 1'b0 || overflow_err !== 1'b1 || depth !== 4'd8)
            begin failures++; $display("FAIL overflow rv=%b ovf=%b depth=%0d exp 0/1/8", resume_valid, overflow_err, depth); end
        idle();
        split_table_num = 3'd7; #1;
        checks++; if (thread_mask !== 32'hFFFF_FF80) begin failures++; $display("FAIL ovf_top got=%h exp ffffff80", thread_mask); end
        split_table_num = 3'd0; #1;
        checks++; if (thread_mask !== 32'h0000_0001) begin failures++; $display("FAIL ovf_bottom got=%h exp 00000001", thread_mask); end
    endtask

    task automatic test_underflow();
        op(2'd3, 1'b0, 32'h300, 32'h0);
        checks++; if (resume_valid !== 1'b0 || underflow_err !== 1'b1 || depth !== 4'd1)
            begin failures++; $display("FAIL underflow rv=%b unf=%b depth=%0d exp 0/1/1", resume_valid, underflow_err, depth); end
        idle();
        checks++; if (overflow_err !== 1'b1 || underflow_err !== 1'b1) begin failures++; $display("FAIL sticky ovf=%b unf=%b exp 1/1", overflow_err, underflow_err); end
    endtask

    task automatic test_back_to_back();
        op(2'd0, 1'b1, 32'h400, 32'h0000_00FF);
        checks++; if (resume_valid !== 1'b1 || resume_warp !== 2'd0 || resume_mask !== 32'h0000_00FF)
            begin failures++; $display("FAIL b2b_w0 rv=%b rw=%0d mask=%h exp 1/0/000000ff", resume_valid, resume_warp, resume_mask); end
        op(2'd1, 1'b1, 32'h500, 32'hFFFF_0000);
        checks++; if (resume_valid !== 1'b1 || resume_warp !== 2'd1 || resume_mask !== 32'hFFFF_0000 || resume_pc !== 32'h500)
            begin failures++; $display("FAIL b2b_w1 rv=%b rw=%0d mask=%h pc=%h exp 1/1/ffff0000/500", resume_valid, resume_warp, resume_mask, resume_pc); end
        op(2'd0, 1'b1, 32'h440, 32'h0000_000F);
        checks++; if (resume_mask !== 32'h0000_000F || depth !== 4'd3) begin failures++; $display("FAIL b2b_nest mask=%h depth=%0d exp 0000000f/3", resume_mask, depth); end
        op(2'd0, 1'b0, 32'h460, 32'h0);
        checks++; if (resume_valid !== 1'b1 || resume_mask !== 32'h0000_00FF) begin failures++; $display("FAIL b2b_join1 rv=%b mask=%h exp 1/000000ff", resume_valid, resume_mask); end
        op(2'd0, 1'b0, 32'h480, 32'h0);
        checks++; if (resume_mask !== 32'hFFFF_FFFF || resume_pc !== 32'h480 || depth !== 4'd1)
            begin failures++; $display("FAIL b2b_join2 mask=%h pc=%h depth=%0d exp ffffffff/480/1", resume_mask, resume_pc, depth); end
        idle();
    endtask

    task automatic test_stall();
        stall = 1'b1;
        split_table_num = 3'd0;
        op(2'd0, 1'b1, 32'h600, 32'h0000_FFFF);
        checks++; if (resume_valid !== 1'b0 || depth !== 4'd1 || thread_mask !== 32'hFFFF_FFFF)
            begin failures++; $display("FAIL stall rv=%b depth=%0d mask=%h exp 0/1/ffffffff", resume_valid, depth, thread_mask); end
        idle();
    endtask

    task automatic test_reset_mid();
        warp_num = 2'd1; activate = 1'b1; updated_pc = 32'h700; cond_mask = 32'h00FF_00FF; valid = 1'b1;
        rst = 1'b1;
        #1;
        checks++; if (overflow_err !== 1'b0 || underflow_err !== 1'b0 || resume_valid !== 1'b0)
            begin failures++; $display("FAIL rst_async ovf=%b unf=%b rv=%b exp 0/0/0", overflow_err, underflow_err, resume_valid); end
        @(posedge clk); #1;
        valid = 1'b0;
        #1 rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (resume_valid !== 1'b0) begin failures++; $display("FAIL rst_no_pulse rv=%b exp 0", resume_valid); end
        warp_num = 2'd2; #1;
        checks++; if (depth !== 4'd1) begin failures++; $display("FAIL rst_depth_w2 depth=%0d exp 1", depth); end
        warp_num = 2'd1; split_table_num = 3'd0; #1;
        checks++; if (thread_mask !== 32'hFFFF_FFFF || depth !== 4'd1) begin failures++; $display("FAIL rst_w1 mask=%h depth=%0d exp ffffffff/1", thread_mask, depth); end
        op(2'd1, 1'b1, 32'h800, 32'h0000_0001);
        checks++; if (resume_valid !== 1'b1 || resume_mask !== 32'h0000_0001 || depth !== 4'd2)
            begin failures++; $display("FAIL rst_recover rv=%b mask=%h depth=%0d exp 1/00000001/2", resume_valid, resume_mask, depth); end
        idle();
    endtask

    initial begin
        test_reset();
        test_diverge_join();
        test_fallthrough();
        test_overflow();
        test_underflow();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
